main_fsm: RTL

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/mips_multi_pkg.sv | 66 ++++++
 rtl/main_fsm_if.sv | 34 +++
 rtl/main_fsm_outdec.sv | 73 +++++++
 rtl/main_fsm.sv | 80 ++++++++
 4 files changed

// File: rtl/mips_multi_pkg.sv
// Shared types for the multicycle MIPS main controller: states, opcodes, ALU op codes.
// MAIN_FSM_BNE_EN adds the BNEEX state, the bne opcode and the bne control bit.
package mips_multi_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTYPEEX,
      S_RTYPEWB,
      S_BEQEX,
      S_ADDIEX,
      S_ADDIWB,
      S_JEX
`ifdef MAIN_FSM_BNE_EN
      , S_BNEEX
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MAIN_FSM_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       alusrca;
      logic       branch;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] alu_op;
      logic       illegal_op;
`ifdef MAIN_FSM_BNE_EN
      logic       bne;
`endif
   } ctl_t;

   function automatic logic op_is_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
`ifdef MAIN_FSM_BNE_EN
         OP_BNE: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Controller-to-datapath bundle: opcode/memory-ready in, enables and selects out.
// MAIN_FSM_BNE_EN adds the bne output.
interface main_fsm_if;
   logic [5:0] op;
   logic       mem_ready;
   logic       pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc, alu_op;
   logic       illegal_op;
`ifdef MAIN_FSM_BNE_EN
   logic       bne;

   modport master (
      input  op, mem_ready,
      output pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst,
      output alusrcb, pcsrc, alu_op, illegal_op, bne
   );
   modport slave (
      output op, mem_ready,
      input  pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst,
      input  alusrcb, pcsrc, alu_op, illegal_op, bne
   );
`else
   modport master (
      input  op, mem_ready,
      output pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst,
      output alusrcb, pcsrc, alu_op, illegal_op
   );
   modport slave (
      output op, mem_ready,
      input  pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst,
      input  alusrcb, pcsrc, alu_op, illegal_op
   );
`endif
endinterface

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control decode for the main controller.
// MAIN_FSM_BNE_EN adds the BNEEX decode.
module main_fsm_outdec
   import mips_multi_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   input  logic       mem_ready,
   input  logic       reset,
   output ctl_t       ctl
);

   always_comb begin
      ctl = '0;
      case (state)
         S_FETCH: begin
            ctl.alusrcb = 2'b01;
            ctl.alu_op  = ALUOP_ADD;
            // reset parks the FSM in FETCH; keep the IR/PC loads quiet while it is held
            ctl.irwrite = mem_ready & ~reset;
            ctl.pcwrite = mem_ready & ~reset;
         end
         S_DECODE: begin
            ctl.alusrcb    = 2'b11;
            ctl.alu_op     = ALUOP_ADD;
            ctl.illegal_op = ~op_is_legal(op);
         end
         S_MEMADR, S_ADDIEX: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = 2'b10;
            ctl.alu_op  = ALUOP_ADD;
         end
         S_MEMRD: ctl.iord = 1'b1;
         S_MEMWB: begin
            ctl.memtoreg = 1'b1;
            ctl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctl.iord     = 1'b1;
            ctl.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            ctl.alusrca = 1'b1;
            ctl.alu_op  = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            ctl.regdst   = 1'b1;
            ctl.regwrite = 1'b1;
         end
         S_BEQEX: begin
            ctl.alusrca = 1'b1;
            ctl.alu_op  = ALUOP_SUB;
            ctl.pcsrc   = 2'b01;
            ctl.branch  = 1'b1;
         end
         S_ADDIWB: ctl.regwrite = 1'b1;
         S_JEX: begin
            ctl.pcsrc   = 2'b10;
            ctl.pcwrite = 1'b1;
         end
`ifdef MAIN_FSM_BNE_EN
         S_BNEEX: begin
            ctl.alusrca = 1'b1;
            ctl.alu_op  = ALUOP_SUB;
            ctl.pcsrc   = 2'b01;
            ctl.bne     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic, output decode.
// MAIN_FSM_BNE_EN adds the BNEEX state and the bne output.
//   state    | meaning
//   FETCH    | read instruction, PC+4 (waits on mem_ready)
//   DECODE   | read regs, branch target, dispatch on op
//   MEMADR   | lw/sw address;  MEMRD/MEMWB load read + writeback;  MEMWR store
//   RTYPEEX/WB | ALU op + rd write;  ADDIEX/WB immediate add + rt write
//   BEQEX/BNEEX | compare and branch;  JEX jump
module main_fsm
   import mips_multi_pkg::*;
(
   input logic        clk,
   input logic        reset,
   main_fsm_if.master bus
);

   state_t state, state_nx;
   ctl_t   ctl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:  state_nx = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_RTYPEEX;
               OP_BEQ:       state_nx = S_BEQEX;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JEX;
`ifdef MAIN_FSM_BNE_EN
               OP_BNE:       state_nx = S_BNEEX;
`endif
               default:      state_nx = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (bus.op == OP_LW)      state_nx = S_MEMRD;
            else if (bus.op == OP_SW) state_nx = S_MEMWR;
            else                      state_nx = S_FETCH;
         end
         S_MEMRD:   state_nx = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_nx = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_nx = S_RTYPEWB;
         S_ADDIEX:  state_nx = S_ADDIWB;
         default:   state_nx = S_FETCH;
      endcase
   end

   main_fsm_outdec u_outdec (
      .state     (state),
      .op        (bus.op),
      .mem_ready (bus.mem_ready),
      .reset     (reset),
      .ctl       (ctl)
   );

   assign bus.pcwrite    = ctl.pcwrite;
   assign bus.memwrite   = ctl.memwrite;
   assign bus.irwrite    = ctl.irwrite;
   assign bus.regwrite   = ctl.regwrite;
   assign bus.alusrca    = ctl.alusrca;
   assign bus.branch     = ctl.branch;
   assign bus.iord       = ctl.iord;
   assign bus.memtoreg   = ctl.memtoreg;
   assign bus.regdst     = ctl.regdst;
   assign bus.alusrcb    = ctl.alusrcb;
   assign bus.pcsrc      = ctl.pcsrc;
   assign bus.alu_op     = ctl.alu_op;
   assign bus.illegal_op = ctl.illegal_op;
`ifdef MAIN_FSM_BNE_EN
   assign bus.bne        = ctl.bne;
`endif

endmodule
